alu_mdu: RTL
============

# alu_mdu

Parametrised, handshaked execute-stage ALU for the RV32I/RV32M core. Performs the full RV32I register/immediate integer operation set in one cycle and the RV32M multiply/divide set iteratively over XLEN cycles, with a registered, back-pressurable result. It sits between decode (operand/func issue) and writeback, and replaces the purely combinational ALU wherever M-extension support or pipeline stalling is needed.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- ENABLE_M, 1: 1 = RV32M ops implemented; 0 = M encodings flagged illegal.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operands and function valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_imm  in  1  1 = I-type (OP-IMM) encoding, 0 = R-type (OP).
- func3  in  3  RISC-V func3.
- func7  in  7  RISC-V func7 (for I-type shifts: imm[11:5]).
- ra_d  in  XLEN  operand A (rs1).
- rb_d  in  XLEN  operand B (rs2 or sign-extended immediate).
- out_valid  out  1  rd_d/illegal valid.
- out_ready  in  1  consumer accepts result.
- rd_d  out  XLEN  result.
- illegal  out  1  encoding unsupported; rd_d = 0 when set.

## Operation
- Decode on {op_imm, func7, func3} at acceptance (in_valid && in_ready); operands latched then.
- R-type, func7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by func3; func7=0100000: SUB (f3=000), SRA (f3=101); func7=0000001 (ENABLE_M=1): f3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Any other func7 → illegal.
- I-type: func7 ignored for f3 ∈ {000,010,011,100,110,111}; f3=001 requires func7=0000000; f3=101 requires func7 ∈ {0000000 (SRLI), 0100000 (SRAI)}; otherwise illegal.
- Shift amount = rb_d[log2(XLEN)-1:0]; upper bits ignored. SRA/SRAI replicate ra_d[XLEN-1].
- SLT signed, SLTU unsigned; result 1 or 0, zero-extended.
- MUL family: 2·XLEN-bit product of |A|·|B| by radix-2 shift-add, sign applied at end. Signedness: MULH s×s, MULHSU s×u, MULHU u×u. MUL returns low XLEN bits, others high XLEN bits.
- DIV family: restoring division on magnitudes; quotient negated if signs differ (DIV), remainder takes dividend sign (REM).
- Fast-path special cases (single cycle, no iteration): divisor 0 → quotient all-ones, remainder = ra_d; signed overflow (A = most-negative, B = −1) → quotient = A, remainder = 0.
- FSM: IDLE → (accept, single-cycle or special/illegal op) DONE; IDLE → (accept, iterative op) CALC; CALC → DONE after XLEN iteration cycles; DONE → IDLE when out_ready. flush in any state → IDLE, result discarded.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, rd_d 0, illegal 0, all datapath registers 0.
- Accept at edge of cycle 0. Single-cycle, special-case and illegal ops: out_valid high in cycle 1. Iterative MUL/DIV: CALC cycles 1..XLEN, out_valid high in cycle XLEN+1.
- out_valid, rd_d, illegal held stable while out_ready low. Handshake completes on the edge where out_valid && out_ready; out_valid drops the next cycle.
- in_ready low from the cycle after acceptance until back in IDLE; next accept earliest the cycle after the output handshake. No overlap.
- in_valid while in_ready low is ignored; the issuer must hold it.
- flush has priority over out_ready and in_valid: in_ready 1, out_valid 0 the next cycle; a concurrent in_valid is not accepted.
- rst_n low mid-operation: outputs go to reset values immediately (asynchronous), no result emitted.

## Test plan
- SUB R-type, ra=5, rb=7 → rd_d=0xFFFF_FFFE, out_valid in cycle 1; SLT(−1, 1)=1, SLTU(0xFFFF_FFFF, 1)=0.
- SRA ra=0x8000_0000, rb=0x21 (masked to 1) → 0xC000_0000; SRLI same operands → 0x4000_0000; I-type f3=001 with func7=0100000 → illegal=1, rd_d=0.
- MULH 0x8000_0000×0x8000_0000 → 0x4000_0000, out_valid in cycle 33; MULHSU(−1, 0xFFFF_FFFF) → 0xFFFF_FFFF; MUL 7×(−3) → 0xFFFF_FFEB.
- DIV 5/0 → 0xFFFF_FFFF and REM 5/0 → 5, both in cycle 1; DIV 0x8000_0000/−1 → 0x8000_0000, REM → 0; REM(−7, 2) → 0xFFFF_FFFF.
- DIVU 100/7 → 14, REMU → 2; hold out_ready low 5 cycles → rd_d/out_valid stable; in_ready returns 1 the cycle after handshake.
- flush in cycle 10 of a DIV → out_valid never asserted, in_ready 1 next cycle, following ADD 1+1 → 2; rst_n pulse mid-MUL → all outputs at reset values.

Source files
------------

// File: rtl/alu_mdu.sv
// Handshaked RV32I/RV32M execute unit: single-cycle integer ops plus iterative
// shift-add multiply and restoring divide, with a back-pressurable result register.
module alu_mdu #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_imm,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] ra_d,
  input  logic [XLEN-1:0] rb_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_d,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
  localparam logic [SHW-1:0]  CNT_LAST   = SHW'(XLEN-1);
  localparam logic [6:0]      F7_BASE    = 7'b0000000;
  localparam logic [6:0]      F7_ALT     = 7'b0100000;
  localparam logic [6:0]      F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic                in_ready_r, out_valid_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     opb_r;
  logic                neg_q_r, neg_rem_r, is_div_r, sel_r;
  logic [SHW-1:0]      cnt_r;
  logic [XLEN-1:0]     rd_r;
  logic                illegal_r;

  logic [SHW-1:0]      shamt_s;
  logic                is_m_s, legal_s, alt_s, iter_s;
  logic                a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, div0_s, ovf_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s, alu_s, res_s;
  logic [XLEN:0]       sum_s, rem_sh_s, diff_s;
  logic [2*XLEN-1:0]   acc_nxt_s, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, calc_res_s;

  // Encoding legality check
  always_comb begin
    shamt_s = rb_d[SHW-1:0];
    alt_s   = (func7 == F7_ALT);
    is_m_s  = ENABLE_M && !op_imm && (func7 == F7_MULDIV);
    legal_s = 1'b0;
    if (op_imm) begin
      case (func3)
        3'b001:  legal_s = (func7 == F7_BASE);
        3'b101:  legal_s = (func7 == F7_BASE) || (func7 == F7_ALT);
        default: legal_s = 1'b1;
      endcase
    end else begin
      case (func7)
        F7_BASE:   legal_s = 1'b1;
        F7_ALT:    legal_s = (func3 == 3'b000) || (func3 == 3'b101);
        F7_MULDIV: legal_s = ENABLE_M;
        default:   legal_s = 1'b0;
      endcase
    end
  end

  // Single-cycle integer result
  always_comb begin
    alu_s = '0;
    case (func3)
      3'b000: begin
        if (!op_imm && alt_s) alu_s = ra_d - rb_d;
        else                  alu_s = ra_d + rb_d;
      end
      3'b001: alu_s = ra_d << shamt_s;
      3'b010: alu_s = {{(XLEN-1){1'b0}}, ($signed(ra_d) < $signed(rb_d))};
      3'b011: alu_s = {{(XLEN-1){1'b0}}, (ra_d < rb_d)};
      3'b100: alu_s = ra_d ^ rb_d;
      3'b101: begin
        if (alt_s) alu_s = $signed(ra_d) >>> shamt_s;
        else       alu_s = ra_d >> shamt_s;
      end
      3'b110: alu_s = ra_d | rb_d;
      3'b111: alu_s = ra_d & rb_d;
      default: alu_s = '0;
    endcase
  end

  // Operand magnitudes, special divide cases and issue result selection
  always_comb begin
    a_sgn_s = func3[2] ? !func3[0] : (func3[1:0] != 2'b11);
    b_sgn_s = func3[2] ? !func3[0] : !func3[1];
    a_neg_s = a_sgn_s && ra_d[XLEN-1];
    b_neg_s = b_sgn_s && rb_d[XLEN-1];
    a_mag_s = a_neg_s ? -ra_d : ra_d;
    b_mag_s = b_neg_s ? -rb_d : rb_d;
    div0_s  = (rb_d == '0);
    ovf_s   = b_sgn_s && (ra_d == MOST_NEG) && (rb_d == ALL_ONES);
    res_s   = '0;
    iter_s  = 1'b0;
    if (!legal_s) begin
      res_s = '0;
    end else if (is_m_s) begin
      if (func3[2] && div0_s)     res_s = func3[1] ? ra_d : ALL_ONES;
      else if (func3[2] && ovf_s) res_s = func3[1] ? '0 : ra_d;
      else                        iter_s = 1'b1;
    end else begin
      res_s = alu_s;
    end
  end

  // One multiply (hi += B when lo[0], shift right) or divide (shift left, trial subtract) step.
  // The same {hi, lo} register serves as {product} and {remainder, quotient}.
  always_comb begin
    sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    rem_sh_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, opb_r};
    if (!is_div_r)         acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
    else if (diff_s[XLEN]) acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    else                   acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    prod_s = neg_q_r ? -acc_nxt_s : acc_nxt_s;
    quo_s  = neg_q_r ? -acc_nxt_s[XLEN-1:0] : acc_nxt_s[XLEN-1:0];
    rem_s  = neg_rem_r ? -acc_nxt_s[2*XLEN-1:XLEN] : acc_nxt_s[2*XLEN-1:XLEN];
    if (is_div_r) calc_res_s = sel_r ? rem_s : quo_s;
    else          calc_res_s = sel_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  // Next-state logic; flush dominates everything
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) state_nxt_s = iter_s ? CALC : DONE;
          else          state_nxt_s = IDLE;
        end
        CALC: begin
          if (cnt_r == CNT_LAST) state_nxt_s = DONE;
          else                   state_nxt_s = CALC;
        end
        DONE: begin
          if (out_ready) state_nxt_s = IDLE;
          else           state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Datapath: operand capture on accept, iteration in CALC, result hold in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      opb_r     <= '0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      is_div_r  <= 1'b0;
      sel_r     <= 1'b0;
      cnt_r     <= '0;
      rd_r      <= '0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      cnt_r     <= '0;
      rd_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            acc_r     <= {{XLEN{1'b0}}, a_mag_s};
            opb_r     <= b_mag_s;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            is_div_r  <= func3[2];
            sel_r     <= func3[2] ? func3[1] : (func3 != 3'b000);
            cnt_r     <= '0;
            rd_r      <= res_s;
            illegal_r <= !legal_s;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + SHW'(1);
          if (cnt_r == CNT_LAST) rd_r <= calc_res_s;
        end
        DONE: begin
          if (out_ready) begin
            rd_r      <= '0;
            illegal_r <= 1'b0;
          end
        end
        default: begin
          rd_r      <= '0;
          illegal_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign rd_d      = rd_r;
  assign illegal   = illegal_r;

endmodule
